// File: rtl/alu_operand_loader.sv
// Operand-entry front end for the board-level ALU demo.
// Debounces the active-low push-buttons, then steps through operand A,
// operand B and opcode capture on each ENTER press. CLEAR returns to the
// start and zeroes the captured values. A one-cycle go pulse marks a
// completed entry.
//
// Ports:
//   CLK      system clock, rising edge
//   nRST     asynchronous active-low reset
//   sw       sw[15:0] magnitude, sw[16] sign/extension, sw[3:0] opcode
//   key_n    raw buttons, active low: [0] ENTER, [1] CLEAR, [3:2] unused
//   port_a   captured operand A (sign-extended switch value)
//   port_b   captured operand B (sign-extended switch value)
//   aluop    captured opcode
//   state_o  0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 DONE
//   valid    high while in DONE
//   go       one-cycle pulse on entry to DONE
module alu_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WORD_W          = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [16:0]       sw,
  input  logic [3:0]        key_n,
  output logic [WORD_W-1:0] port_a,
  output logic [WORD_W-1:0] port_b,
  output logic [3:0]        aluop,
  output logic [1:0]        state_o,
  output logic              valid,
  output logic              go
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned EXT_W = WORD_W - 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_LOAD_A  = 2'd0;
  localparam logic [1:0] S_LOAD_B  = 2'd1;
  localparam logic [1:0] S_LOAD_OP = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Two-flop synchronizer for all four buttons; released level is 1.
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Spare buttons are synchronized only; they never reach the FSM.
  logic unused_keys;
  assign unused_keys = ^sync2[3:2];

  // Debounce ENTER and CLEAR: a level must differ for DEBOUNCE_CYCLES
  // consecutive cycles before it is accepted; any match restarts the count.
  logic [1:0]       deb;
  logic [1:0]       prev;
  logic [CNT_W-1:0] cnt [2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      deb  <= 2'b11;
      prev <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Falling debounced level = one press event; release never fires.
  logic enter_evt_c;
  logic clear_evt_c;
  assign enter_evt_c = prev[0] & ~deb[0];
  assign clear_evt_c = prev[1] & ~deb[1];

  logic [WORD_W-1:0] sw_ext_c;
  assign sw_ext_c = {{EXT_W{sw[16]}}, sw[15:0]};

  // FSM state and captured outputs.
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WORD_W-1:0] a_nxt;
  logic [WORD_W-1:0] b_nxt;
  logic [3:0]        op_nxt;
  logic              go_nxt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= S_LOAD_A;
      port_a <= '0;
      port_b <= '0;
      aluop  <= '0;
      valid  <= 1'b0;
      go     <= 1'b0;
    end else begin
      state  <= state_nxt;
      port_a <= a_nxt;
      port_b <= b_nxt;
      aluop  <= op_nxt;
      valid  <= (state_nxt == S_DONE);
      go     <= go_nxt;
    end
  end

  // Next state and capture; CLEAR takes priority over a coincident ENTER.
  always_comb begin
    state_nxt = state;
    a_nxt     = port_a;
    b_nxt     = port_b;
    op_nxt    = aluop;
    go_nxt    = 1'b0;
    if (clear_evt_c) begin
      state_nxt = S_LOAD_A;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
    end else if (enter_evt_c) begin
      case (state)
        S_LOAD_A: begin
          a_nxt     = sw_ext_c;
          state_nxt = S_LOAD_B;
        end
        S_LOAD_B: begin
          b_nxt     = sw_ext_c;
          state_nxt = S_LOAD_OP;
        end
        S_LOAD_OP: begin
          op_nxt    = sw[3:0];
          state_nxt = S_DONE;
          go_nxt    = 1'b1;
        end
        S_DONE: begin
          state_nxt = S_LOAD_A;
        end
        default: begin
          state_nxt = S_LOAD_A;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: button presses of known duration are
// scored against an abstract model of the entry sequence; a monitor
// compares every visible output change against the expected queue,
// including the edge at which it must appear.
module tb_alu_operand_loader;

  localparam int D = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [16:0] sw;
  logic [3:0]  key_n;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  aluop;
  logic [1:0]  state_o;
  logic        valid;
  logic        go;

  alu_operand_loader #(
    .DEBOUNCE_CYCLES(D),
    .WORD_W(32)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .sw(sw),
    .key_n(key_n),
    .port_a(port_a),
    .port_b(port_b),
    .aluop(aluop),
    .state_o(state_o),
    .valid(valid),
    .go(go)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          st;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          at;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // Abstract model: entry step 0..3 and the three captured fields.
  int          m_st = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [3:0]  m_op = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endfunction

  function automatic logic [31:0] ext(input logic [16:0] v);
    return {{16{v[16]}}, v[15:0]};
  endfunction

  function automatic void model_reset();
    m_st = 0;
    m_a  = '0;
    m_b  = '0;
    m_op = '0;
  endfunction

  // A press sampled first at edge n+1 acts at edge n+D+3.
  function automatic void model_event(input bit e, input bit c, input logic [16:0] swv, input int n);
    int          st;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    exp_t        x;
    st = m_st; a = m_a; b = m_b; op = m_op;
    if (c) begin
      st = 0; a = '0; b = '0; op = '0;
    end else if (e) begin
      if (st == 0) a = ext(swv);
      else if (st == 1) b = ext(swv);
      else if (st == 2) op = swv[3:0];
      st = (st + 1) % 4;
    end
    if (st != m_st || a !== m_a || b !== m_b || op !== m_op) begin
      x.st = st; x.a = a; x.b = b; x.op = op; x.at = n + D + 3;
      q.push_back(x);
    end
    m_st = st; m_a = a; m_b = b; m_op = op;
  endfunction

  // Monitor: any output change must match the head of the queue.
  int          p_st = 0;
  logic [31:0] p_a = '0;
  logic [31:0] p_b = '0;
  logic [3:0]  p_op = '0;
  logic        p_v = 1'b0;

  always @(negedge CLK) begin
    bit   exp_go;
    exp_t e;
    exp_go = 1'b0;
    if (!nRST) begin
      p_st = 0; p_a = '0; p_b = '0; p_op = '0; p_v = 1'b0;
    end else begin
      if (int'(state_o) != p_st || port_a !== p_a || port_b !== p_b || aluop !== p_op || valid !== p_v) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_change at edge %0d: state=%0d a=0x%0h b=0x%0h op=0x%0h valid=%0b, required no change",
                   cyc, state_o, port_a, port_b, aluop, valid);
        end else begin
          e = q.pop_front();
          check("latency_edge", cyc, e.at);
          check("state", 32'(state_o), e.st);
          check("port_a", port_a, e.a);
          check("port_b", port_b, e.b);
          check("aluop", 32'(aluop), 32'(e.op));
          check("valid", 32'(valid), 32'(e.st == 3));
          exp_go = (e.st == 3);
        end
        p_st = int'(state_o); p_a = port_a; p_b = port_b; p_op = aluop; p_v = valid;
      end
      if (q.size() > 0 && cyc > q[0].at) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_change: expected state=%0d at edge %0d, got state=%0d at edge %0d",
                 e.st, e.at, state_o, cyc);
      end
      check("go", 32'(go), 32'(exp_go));
    end
  end

  // which: 0 ENTER, 1 CLEAR, 2 both, 3 key2, 4 key3
  task automatic press(input int which, input int hold, input logic [16:0] swv);
    int n;
    bit e;
    bit c;
    @(posedge CLK); #1;
    sw = swv;
    n = cyc;
    e = (which == 0 || which == 2);
    c = (which == 1 || which == 2);
    key_n = {~(which == 4), ~(which == 3), ~c, ~e};
    if (hold >= D) model_event(e, c, swv, n);
    repeat (hold) @(posedge CLK);
    #1;
    key_n = 4'hF;
    repeat (4) @(posedge CLK);
    #1;
    sw = 17'($urandom);
    repeat (D + 6) @(posedge CLK);
  endtask

  task automatic bounce_then_hold();
    int n;
    @(posedge CLK); #1;
    sw = 17'($urandom);
    for (int i = 0; i < 40; i++) begin
      key_n[0] = (i % 2 == 1);
      repeat (5) @(posedge CLK);
      #1;
    end
    key_n[0] = 1'b0;
    n = cyc;
    model_event(1'b1, 1'b0, sw, n);
    repeat (30) @(posedge CLK);
    #1;
    key_n = 4'hF;
    repeat (D + 10) @(posedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_a"}, port_a, 32'd0);
    check({tag, "_b"}, port_b, 32'd0);
    check({tag, "_op"}, 32'(aluop), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_go"}, 32'(go), 32'd0);
  endtask

  initial begin
    logic [16:0] swr;
    int          n;
    int          r;
    int          which;
    nRST  = 1'b0;
    key_n = 4'hF;
    sw    = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    nRST = 1'b1;
    repeat (100) @(posedge CLK);
    check_zero("idle");

    // Full entry sequence
    press(0, 20, 17'h1FFFE);
    press(0, 20, 17'h00005);
    press(0, 20, 17'h00003);
    check("seq_a", port_a, 32'hFFFF_FFFE);
    check("seq_b", port_b, 32'h0000_0005);
    check("seq_op", 32'(aluop), 32'h3);
    check("seq_state", 32'(state_o), 32'd3);
    check("seq_valid", 32'(valid), 32'd1);

    // DONE -> LOAD_A, bounce rejection, short pulse, then CLEAR from LOAD_OP
    press(0, 20, 17'($urandom));
    bounce_then_hold();
    check("bounce_state", 32'(state_o), 32'd1);
    press(0, 15, 17'($urandom));
    check("short_pulse_state", 32'(state_o), 32'd1);
    press(0, 16, 17'($urandom));
    check("min_hold_state", 32'(state_o), 32'd2);
    press(1, 20, 17'($urandom));
    check_zero("clear");

    // CLEAR and ENTER together
    press(0, 20, 17'($urandom));
    press(0, 20, 17'($urandom));
    press(2, 20, 17'h1ABCD);
    check_zero("both");

    // Long hold gives one event only
    press(0, 1000, 17'h0_1234);
    check("hold_state", 32'(state_o), 32'd1);
    check("hold_a", port_a, 32'h0000_1234);
    press(0, 20, 17'($urandom));
    check("hold2_state", 32'(state_o), 32'd2);

    // Reset in mid-debounce with ENTER held through reset
    press(1, 20, 17'($urandom));
    press(0, 20, 17'($urandom));
    @(posedge CLK); #1;
    swr = 17'($urandom);
    sw = swr;
    key_n[0] = 1'b0;
    repeat (8) @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    n = cyc;
    model_event(1'b1, 1'b0, swr, n);
    repeat (25) @(posedge CLK);
    #1;
    key_n = 4'hF;
    repeat (30) @(posedge CLK);
    check("post_reset_state", 32'(state_o), 32'd1);
    check("post_reset_a", port_a, ext(swr));

    // Random presses, holds straddling the debounce threshold
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 19);
      if (r < 12) which = 0;
      else if (r < 15) which = 1;
      else if (r < 17) which = 2;
      else if (r < 19) which = 3;
      else which = 4;
      press(which, $urandom_range(8, 40), 17'($urandom));
    end

    repeat (40) @(posedge CLK);
    check("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
